rx_uart128: RTL
===============

Name: rx_uart128

Overview:
- Receive-side counterpart of the 128-bit UART transmit path.
- Deserialises the 8N1 serial line into bytes.
- Assembles 16 consecutive bytes into one 128-bit word and pulses a done flag when the word is complete.
- Byte order mirrors the transmit side: the first byte received lands in data_out[127:120].

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range is 4 or greater.
- TIMEOUT_BITS, 20, idle bit-times before a partial word is discarded (used only with RX_TIMEOUT_EN).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- u_rx  input  1  serial line; idles high; asynchronous to clk.
- en_rx  input  1  receive enable; when low, the block idles and discards any partial byte or word.
- data_out  output  128  last completed word; holds its value until the next word completes.
- u_rx_done  output  1  one-cycle pulse when data_out is updated.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- rx_timeout  output  1  one-cycle pulse when a partial word is discarded on idle timeout; tied 0 without RX_TIMEOUT_EN.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: data_out=0, u_rx_done=0, frame_err=0, rx_timeout=0, state=IDLE, byte count=0, assembly register=0, synchroniser flops=1.
- Synchroniser: u_rx passes through 2 flops before use. All references below are to the synchronised line (rxs).
- Bit counter: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
- FSM IDLE: wait for rxs==0 with en_rx==1, then go to START with counter=0.
- FSM START: at counter==CLKS_PER_BIT/2-1 (mid start bit):
  - rxs==0: go to DATA, reset counter.
  - rxs==1: glitch; go back to IDLE, no outputs.
- FSM DATA: sample rxs every CLKS_PER_BIT cycles, at mid-bit.
  - Data is LSB first; bit i goes to byte[i].
  - After bit 7, go to STOP.
- FSM STOP: sample at mid stop bit, then go to IDLE immediately, with no wait for bit end, so back-to-back frames are accepted.
  - rxs==1: byte is valid; asm <= {asm[119:0], byte}; count++.
  - rxs==0: pulse frame_err for 1 cycle; discard the byte; count <= 0, so the whole partial word is dropped.
- Word completion: a valid byte arriving with count==15:
  - data_out <= {asm[119:0], byte}.
  - u_rx_done=1 in the next cycle.
  - count <= 0.
- Latency: u_rx_done rises 1 clk after the mid-stop-bit sample of byte 16.
- en_rx deasserted in any state: next cycle state=IDLE and count=0; data_out is unchanged.
- Reset mid-frame: returns immediately to reset values. A byte already in flight on the line is not recovered. Because the line may be mid-byte when reset releases, reception resumes only after IDLE sees the next falling edge.
- Simultaneous events: frame_err and u_rx_done are never both asserted, since a bad stop bit never completes a word.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined: an idle counter runs while state==IDLE and count>0.
  - It resets whenever a start bit is detected.
  - On reaching TIMEOUT_BITS*CLKS_PER_BIT cycles: count <= 0 and rx_timeout pulses for 1 cycle.
- Undefined: no idle counter; a partial word waits indefinitely; rx_timeout is constant 0.

Test Plan:
All tests use CLKS_PER_BIT=16.
- Clean word: send 16 frames 0x00,0x01,...,0x0F back-to-back, en_rx=1 -> data_out=128'h000102030405060708090A0B0C0D0E0F; u_rx_done high exactly 1 cycle; frame_err never asserted.
- Glitch reject: drive u_rx low for 4 cycles, then high; follow with a clean word of 0xA5 ×16 -> no pulse from the glitch; then data_out={16{8'hA5}} with a single done pulse.
- Framing error: send 5 good bytes, then a 6th with the stop bit held low, then 16 bytes 0xF0..0xFF -> frame_err pulses once; data_out=128'hF0F1...FF; exactly one u_rx_done.
- Enable/reset abort: send 8 bytes, drop en_rx for 2 cycles (or assert reset mid-byte), then send 16 bytes 0x11 -> data_out={16{8'h11}}; none of the first 8 bytes appear; after reset, data_out=0 until completion.
- Timeout (RX_TIMEOUT_EN, TIMEOUT_BITS=20): send 3 bytes, idle 400 cycles, then 16 bytes 0x3C -> rx_timeout pulses once at 320 idle cycles; data_out={16{8'h3C}}. Without the macro, the same stimulus gives data_out={3C,3C,3C,... first 13 bytes padded per order}. Check only that rx_timeout stays 0 and u_rx_done occurs after the 13th 0x3C byte.

Source files
------------

// File: rtl/rx_uart128.sv
// rx_uart128 - 8N1 UART receiver that assembles 16 bytes into one 128-bit word.
//
// The first byte received ends up in data_out[127:120], mirroring the transmit side.
// Bytes are only kept when their stop bit is high. A bad stop bit drops the whole
// partial word.
//
// Optional feature (macro RX_TIMEOUT_EN): a partial word is discarded after
// TIMEOUT_BITS idle bit-times. Without the macro, rx_timeout is tied low.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   u_rx       serial line, idles high, asynchronous to clk
//   en_rx      receive enable; low forces idle and drops any partial byte/word
//   data_out   last completed 128-bit word (held until the next word completes)
//   u_rx_done  one-cycle pulse when data_out updates
//   frame_err  one-cycle pulse when a stop bit is sampled low
//   rx_timeout one-cycle pulse when a partial word is dropped on idle timeout
module rx_uart128 #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         u_rx,
    input  logic         en_rx,
    output logic [127:0] data_out,
    output logic         u_rx_done,
    output logic         frame_err,
    output logic         rx_timeout
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4 || TIMEOUT_BITS < 1) begin : g_bad_params
        $error("rx_uart128: CLKS_PER_BIT must be >= 4 and TIMEOUT_BITS >= 1");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_byte;
    logic [3:0]       byte_cnt;
    logic [119:0]     asm_q;     // bytes 1..15 of the word in progress
    logic             rx_meta;
    logic             rxs;

`ifdef RX_TIMEOUT_EN
    localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TO_W      = $clog2(TO_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
    logic [TO_W-1:0] idle_cnt;
`else
    assign rx_timeout = 1'b0;
`endif

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= u_rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            rx_byte   <= '0;
            byte_cnt  <= '0;
            asm_q     <= '0;
            data_out  <= '0;
            u_rx_done <= 1'b0;
            frame_err <= 1'b0;
`ifdef RX_TIMEOUT_EN
            idle_cnt   <= '0;
            rx_timeout <= 1'b0;
`endif
        end else begin
            u_rx_done <= 1'b0;
            frame_err <= 1'b0;
`ifdef RX_TIMEOUT_EN
            rx_timeout <= 1'b0;
`endif
            if (!en_rx) begin
                state    <= IDLE;
                clk_cnt  <= '0;
                byte_cnt <= '0;
`ifdef RX_TIMEOUT_EN
                idle_cnt <= '0;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                        clk_cnt <= '0;
                        if (!rxs) begin
                            state <= START;
`ifdef RX_TIMEOUT_EN
                            idle_cnt <= '0;
                        end else if (byte_cnt != 4'd0) begin
                            if (idle_cnt == TO_LAST) begin
                                idle_cnt   <= '0;
                                byte_cnt   <= '0;
                                rx_timeout <= 1'b1;
                            end else begin
                                idle_cnt <= idle_cnt + 1'b1;
                            end
                        end else begin
                            idle_cnt <= '0;
`endif
                        end
                    end

                    START: begin
                        if (clk_cnt == HALF_BIT) begin
                            // Line back high at mid start bit: treat as a glitch.
                            clk_cnt <= '0;
                            bit_idx <= '0;
                            state   <= rxs ? IDLE : DATA;
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end

                    DATA: begin
                        // Counting from mid start bit, each full bit period lands mid-bit.
                        if (clk_cnt == LAST_TICK) begin
                            clk_cnt          <= '0;
                            rx_byte[bit_idx] <= rxs;
                            bit_idx          <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end

                    STOP: begin
                        // Back to IDLE at mid stop bit so a following start edge is not missed.
                        if (clk_cnt == LAST_TICK) begin
                            clk_cnt <= '0;
                            state   <= IDLE;
                            if (rxs) begin
                                asm_q <= {asm_q[111:0], rx_byte};
                                if (byte_cnt == 4'd15) begin
                                    data_out  <= {asm_q, rx_byte};
                                    u_rx_done <= 1'b1;
                                    byte_cnt  <= '0;
                                end else begin
                                    byte_cnt <= byte_cnt + 4'd1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                byte_cnt  <= '0;
                            end
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
